// File: rtl/display_scanner_pkg.sv
// Shared definitions for the DigiLock display path: symbol codes understood
// by the binary-to-segment encoder, scanner state encoding and width helpers.
package display_pkg;

  typedef logic [4:0] sym_t;

  // Blank symbol: the encoder lights no segments for this code.
  localparam sym_t SYM_NULL  = 5'h00;

  // Decimal digits occupy a contiguous block starting at SYM_D0.
  localparam sym_t SYM_D0    = 5'h01;
  localparam sym_t SYM_D1    = 5'h02;
  localparam sym_t SYM_D2    = 5'h03;
  localparam sym_t SYM_D3    = 5'h04;
  localparam sym_t SYM_D4    = 5'h05;
  localparam sym_t SYM_D5    = 5'h06;
  localparam sym_t SYM_D6    = 5'h07;
  localparam sym_t SYM_D7    = 5'h08;
  localparam sym_t SYM_D8    = 5'h09;
  localparam sym_t SYM_D9    = 5'h0A;

  // Letters used by lock status messages (OPEN, LOC, Err, ...).
  localparam sym_t SYM_A     = 5'h0B;
  localparam sym_t SYM_B     = 5'h0C;
  localparam sym_t SYM_C     = 5'h0D;
  localparam sym_t SYM_D     = 5'h0E;
  localparam sym_t SYM_E     = 5'h0F;
  localparam sym_t SYM_DASH  = 5'h10;
  localparam sym_t SYM_F     = 5'h11;
  localparam sym_t SYM_L     = 5'h12;
  localparam sym_t SYM_P     = 5'h13;
  localparam sym_t SYM_N     = 5'h14;
  localparam sym_t SYM_U     = 5'h15;
  localparam sym_t SYM_H     = 5'h16;
  localparam sym_t SYM_R     = 5'h17;
  localparam sym_t SYM_T     = 5'h18;
  localparam sym_t SYM_O     = SYM_D0;

  // Scanner states: all anodes dark, or one digit lit.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Symbol code of a decimal digit 0..9; out-of-range values map to a dash.
  function automatic sym_t sym_digit(input logic [3:0] d);
    sym_t code;
    if (d <= 4'd9) begin
      code = SYM_D0 + {1'b0, d};
    end else begin
      code = SYM_DASH;
    end
    return code;
  endfunction

endpackage

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner. Each digit slot starts with a short
// all-dark gap (anti-ghosting) followed by the digit's stored symbol and its
// active-low anode. All outputs are registered and change on the same edge as
// the state/counter they reflect.
module display_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(N_DIGITS)-1:0] wr_idx,
  input  logic [4:0]                  wr_sym,
  input  logic                        blank_all,
  output logic [4:0]                  sym_out,
  output logic [N_DIGITS-1:0]         an_out,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = clog2_min1(N_DIGITS);
  localparam int CNT_W = clog2_min1(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  // Symbol store: one plain register per digit.
  sym_t store_r [N_DIGITS];

  logic [0:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [0:0]          state_s;
  logic [CNT_W-1:0]    cnt_s;
  logic [IDX_W-1:0]    idx_s;
  sym_t                sym_s;
  logic [N_DIGITS-1:0] an_s;

  // Symbol store update; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DIGITS; i++) begin
      if (rst) begin
        store_r[i] <= SYM_NULL;
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        store_r[i] <= wr_sym;
      end
    end
  end

  // Slot sequencing: BLANK for the first BLANK_CYCLES counts, SHOW for the
  // rest, then advance to the next digit with the counter back at zero.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = digit_idx;
    case (state_r)
      ST_BLANK: begin
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_SHOW;
        end else begin
          state_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_r == SLOT_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_BLANK;
          if (digit_idx == IDX_LAST) begin
            idx_s = IDX_ZERO;
          end else begin
            idx_s = digit_idx + IDX_ONE;
          end
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = ST_SHOW;
        end
      end
      default: begin
        state_s = ST_BLANK;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Output values for the state being entered. The store is read before this
  // edge's write lands, so a write to the lit digit appears one edge later.
  always_comb begin
    an_s  = {N_DIGITS{1'b1}};
    sym_s = SYM_NULL;
    if (state_s == ST_SHOW) begin
      sym_s        = store_r[idx_s];
      an_s[idx_s]  = 1'b0;
    end else begin
      sym_s = SYM_NULL;
    end
    if (blank_all) begin
      an_s = {N_DIGITS{1'b1}};
    end else begin
      an_s = an_s;
    end
  end

  // Scanner state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_BLANK;
      cnt_r     <= CNT_ZERO;
      digit_idx <= IDX_ZERO;
      sym_out   <= SYM_NULL;
      an_out    <= {N_DIGITS{1'b1}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      digit_idx <= idx_s;
      sym_out   <= sym_s;
      an_out    <= an_s;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner. The reference model tracks the
// number of edges since reset and derives slot, phase and digit arithmetically.
module tb_display_scanner;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [4:0] wr_sym;
  logic       blank_all;
  logic [4:0] sym_out;
  logic [3:0] an_out;
  logic [1:0] digit_idx;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int         t;
  logic [4:0] ref_store [N];
  logic [3:0] exp_an;
  logic [4:0] exp_sym;
  logic [1:0] exp_idx;

  always #5 clk = ~clk;

  display_scanner #(
    .N_DIGITS    (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_sym   (wr_sym),
    .blank_all(blank_all),
    .sym_out  (sym_out),
    .an_out   (an_out),
    .digit_idx(digit_idx)
  );

  task automatic drive(input logic en, input logic [1:0] idx, input logic [4:0] sym,
                       input logic blk);
    wr_en     = en;
    wr_idx    = idx;
    wr_sym    = sym;
    blank_all = blk;
  endtask

  // One clock edge: update the reference model with the inputs the DUT sees,
  // then move to the falling edge where outputs are sampled.
  task automatic advance();
    int phase;
    int dig;
    @(posedge clk);
    if (rst) begin
      t = 0;
      for (int i = 0; i < N; i++) ref_store[i] = 5'h00;
      exp_an  = 4'b1111;
      exp_sym = 5'h00;
      exp_idx = 2'd0;
    end else begin
      t     = t + 1;
      phase = t % P;
      dig   = (t / P) % N;
      exp_idx = dig[1:0];
      exp_sym = (phase < B) ? 5'h00 : ref_store[dig];
      exp_an  = (blank_all || phase < B) ? 4'b1111 : ~(4'b0001 << dig);
      if (wr_en && int'(wr_idx) < N) ref_store[int'(wr_idx)] = wr_sym;
    end
    @(negedge clk);
  endtask

  function automatic int cur_phase();
    return t % P;
  endfunction

  function automatic int cur_digit();
    return (t / P) % N;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    advance();
    advance();
    vectors++;
    if ({an_out, sym_out, digit_idx} !== {4'b1111, 5'h00, 2'd0}) begin
      miscompares++;
      $display("FAIL reset: an=%b sym=%h idx=%0d, want an=1111 sym=00 idx=0", an_out, sym_out, digit_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 40; i++) begin
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {exp_an, exp_sym, exp_idx}) begin
        miscompares++;
        $display("FAIL idle_scan t=%0d: an=%b sym=%h idx=%0d, want an=%b sym=%h idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_an, exp_sym, exp_idx);
      end
    end
  endtask

  task automatic test_store_frame();
    for (int d = 0; d < N; d++) begin
      drive(1'b1, d[1:0], 5'(d + 1), 1'b0);
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {exp_an, exp_sym, exp_idx}) begin
        miscompares++;
        $display("FAIL store_write t=%0d: an=%b sym=%h idx=%0d, want an=%b sym=%h idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_an, exp_sym, exp_idx);
      end
    end
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    for (int i = 0; i < N * P; i++) begin
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {exp_an, exp_sym, exp_idx}) begin
        miscompares++;
        $display("FAIL store_frame t=%0d: an=%b sym=%h idx=%0d, want an=%b sym=%h idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_an, exp_sym, exp_idx);
      end
    end
  endtask

  task automatic test_write_shown();
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    for (int i = 0; i < 2 * N * P && !(cur_digit() == 2 && cur_phase() == 4); i++) advance();
    drive(1'b1, 2'd2, 5'h10, 1'b0);
    advance();
    vectors++;
    if ({an_out, sym_out} !== {4'b1011, 5'h03} || sym_out !== exp_sym) begin
      miscompares++;
      $display("FAIL write_shown_edge: an=%b sym=%h, want an=1011 sym=03", an_out, sym_out);
    end
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    advance();
    vectors++;
    if ({an_out, sym_out} !== {4'b1011, 5'h10} || sym_out !== exp_sym) begin
      miscompares++;
      $display("FAIL write_shown_next: an=%b sym=%h, want an=1011 sym=10", an_out, sym_out);
    end
  endtask

  task automatic test_coincident_write();
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    for (int i = 0; i < 2 * N * P && !(cur_digit() == 1 && cur_phase() == 1); i++) advance();
    drive(1'b1, 2'd1, 5'h1A, 1'b0);
    advance();
    vectors++;
    if ({an_out, sym_out} !== {4'b1101, 5'h02} || sym_out !== exp_sym) begin
      miscompares++;
      $display("FAIL coincident_entry: an=%b sym=%h, want an=1101 sym=02", an_out, sym_out);
    end
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    advance();
    vectors++;
    if ({an_out, sym_out} !== {4'b1101, 5'h1A} || sym_out !== exp_sym) begin
      miscompares++;
      $display("FAIL coincident_next: an=%b sym=%h, want an=1101 sym=1a", an_out, sym_out);
    end
  endtask

  task automatic test_rst_mid_slot();
    drive(1'b1, 2'd3, 5'h1F, 1'b0);
    advance();
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    for (int i = 0; i < 2 * N * P && !(cur_digit() == 3 && cur_phase() == 5); i++) advance();
    vectors++;
    if ({an_out, sym_out} !== {4'b0111, 5'h1F}) begin
      miscompares++;
      $display("FAIL rst_pre: an=%b sym=%h, want an=0111 sym=1f", an_out, sym_out);
    end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    vectors++;
    if ({an_out, sym_out, digit_idx} !== {4'b1111, 5'h00, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_mid: an=%b sym=%h idx=%0d, want an=1111 sym=00 idx=0", an_out, sym_out, digit_idx);
    end
    for (int i = 0; i < N * P; i++) begin
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {exp_an, 5'h00, exp_idx}) begin
        miscompares++;
        $display("FAIL rst_store_clear t=%0d: an=%b sym=%h idx=%0d, want an=%b sym=00 idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_an, exp_idx);
      end
    end
  endtask

  task automatic test_blank_all();
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 5'($urandom), 1'b1);
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {4'b1111, exp_sym, exp_idx}) begin
        miscompares++;
        $display("FAIL blank_all t=%0d: an=%b sym=%h idx=%0d, want an=1111 sym=%h idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_sym, exp_idx);
      end
    end
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    for (int i = 0; i < 2 * P; i++) begin
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {exp_an, exp_sym, exp_idx}) begin
        miscompares++;
        $display("FAIL blank_release t=%0d: an=%b sym=%h idx=%0d, want an=%b sym=%h idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_an, exp_sym, exp_idx);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 5'($urandom),
            $urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 99) == 0);
      advance();
      vectors++;
      if ({an_out, sym_out, digit_idx} !== {exp_an, exp_sym, exp_idx}) begin
        miscompares++;
        $display("FAIL random t=%0d: an=%b sym=%h idx=%0d, want an=%b sym=%h idx=%0d",
                 t, an_out, sym_out, digit_idx, exp_an, exp_sym, exp_idx);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 5'h00, 1'b0);
    t = 0;
    @(negedge clk);
    test_reset();
    test_idle_scan();
    test_store_frame();
    test_write_shown();
    test_coincident_write();
    test_rst_mid_slot();
    test_blank_all();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the DigiLock seven-segment display bank. Holds one 5-bit symbol code per digit, written by the lock controller, and scans the digits in turn. For each digit it emits that digit's symbol code toward the binary-to-segment encoder and the matching active-low anode enable. A blanking gap between digits prevents ghosting.

## Interface
- N_DIGITS, 4: number of multiplexed digits (2..8).
- PRESCALE, 50000: clk cycles per digit slot, blank gap included; must exceed BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off (≥1).

- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the symbol store; one write per cycle.
- wr_idx  in  $clog2(N_DIGITS)  digit to write; 0 is the rightmost digit.
- wr_sym  in  5  symbol code to store.
- blank_all  in  1  while high, all anodes are forced off; scanning continues.
- sym_out  out  5  symbol code for the encoder input.
- an_out  out  N_DIGITS  active-low anode enables; at most one bit low.
- digit_idx  out  $clog2(N_DIGITS)  digit currently in its slot.

## Operation
- Reset values:
  - Every stored symbol is SYM_NULL.
  - sym_out = SYM_NULL, an_out = all ones, digit_idx = 0.
  - State = BLANK, slot counter = 0.
- Store: on wr_en with wr_idx < N_DIGITS, entry[wr_idx] takes wr_sym at that edge. A write with wr_idx ≥ N_DIGITS is ignored.
- State machine, with a slot counter cnt running 0..PRESCALE-1:
  - BLANK: an_out = all ones, sym_out = SYM_NULL. When cnt = BLANK_CYCLES-1, go to SHOW.
  - SHOW: an_out has bit digit_idx low, sym_out = entry[digit_idx]. When cnt = PRESCALE-1: cnt ← 0, digit_idx ← digit_idx+1, wrapping N_DIGITS-1 → 0, and go to BLANK.
- blank_all overrides an_out only. State, cnt, digit_idx and sym_out evolve unchanged.
- Codes are opaque. The scanner never decodes them except to emit SYM_NULL during blanking.

## Timing
- All outputs come directly from flops and are updated on the same edge as the state and cnt transition.
- BLANK lasts exactly BLANK_CYCLES cycles and SHOW lasts PRESCALE-BLANK_CYCLES cycles, so a full frame is N_DIGITS·PRESCALE cycles.
- Write to the digit currently shown, at edge k: sym_out carries the new code from edge k+1. No tearing: old code through edge k, new code afterwards.
- A write landing on the same edge as a BLANK→SHOW transition for that digit: sym_out shows the new code one cycle after SHOW entry. It shows the old code for exactly one cycle.
- blank_all: an_out goes all ones on the edge after it is sampled high. On release, the current state's value is restored on the next edge.
- rst mid-slot: on the next edge, everything returns to reset values, including the store.

## Structure
- Package display_pkg holds:
  - SYM_NULL = 5'h00 and SYM_DASH = 5'h10.
  - The remaining symbol-code constants shared with the encoder.
  - Function clog2_min1, which returns at least 1 bit for widths.
- Single module, no sub-modules. The store is a plain register array, not a RAM.

## Test plan
Benches use PRESCALE=8, BLANK_CYCLES=2, N_DIGITS=4.
- Reset then idle 40 cycles → the pattern repeats every 8 cycles: 2 cycles with an_out=4'b1111, then 6 cycles with one bit low (1110, 1101, 1011, 0111 in turn). sym_out stays 5'h00 throughout. digit_idx wraps 3→0 at cycle 32.
- Write 5'h01, 5'h02, 5'h03, 5'h04 to digits 0..3, then run one frame → sym_out = entry[digit_idx] during each SHOW and 5'h00 during each BLANK.
- Write 5'h10 to digit 2 mid-SHOW of digit 2 → sym_out changes on the following edge, an_out stays 4'b1011.
- Write with wr_idx=3, then assert rst at cycle 5 of slot 3 → the next edge gives an_out=4'b1111, sym_out=5'h00, digit_idx=0, and the store is cleared.
- Hold blank_all for 20 cycles → an_out stays 4'b1111 one edge later. digit_idx keeps advancing. On release, the scan phase matches a reference counter.
